// File: rtl/riscv_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package riscv_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXLO,
    ST_FIXHI,
    ST_DONE
  } mul_state_t;

  localparam int unsigned MUL_LATENCY = 35;
  localparam int unsigned MUL_ITERS   = 32;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple adder with carry in/out, shared by accumulate and negate steps.
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative shift-add 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are made unsigned at load; the 64-bit product is negated in two fixup cycles.
module mul_iter_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  mul_state_t      state_q, state_d;
  mul_op_t         op_q;
  logic [XLEN-1:0] mcand_q, lo_q, acc_hi_q, result_q;
  logic [4:0]      cnt_q;
  logic            neg_q, c_q;

  logic [XLEN-1:0] add_a, add_b, add_sum, sel_res;
  logic            add_cin, add_cout;
  logic            s1, s2, accept;

  adder_32bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i && !flush_i) state_d = ST_CALC;
      ST_CALC: begin
        if (flush_i)                            state_d = ST_IDLE;
        else if (cnt_q == 5'(MUL_ITERS - 1))    state_d = ST_FIXLO;
      end
      ST_FIXLO: state_d = flush_i ? ST_IDLE : ST_FIXHI;
      ST_FIXHI: state_d = flush_i ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == ST_CALC) || (state_q == ST_FIXLO) || (state_q == ST_FIXHI);
    valid_o = (state_q == ST_DONE) && !flush_i;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      ST_CALC: begin
        add_a = acc_hi_q;
        add_b = lo_q[0] ? mcand_q : '0;
      end
      ST_FIXLO: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
      end
      ST_FIXHI: begin
        add_a   = ~acc_hi_q;
        add_cin = c_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1      = ((mul_op_t'(op_i) == MULH) || (mul_op_t'(op_i) == MULHSU)) && rs1_i[XLEN-1];
    s2      = (mul_op_t'(op_i) == MULH) && rs2_i[XLEN-1];
    accept  = (state_q == ST_IDLE) && start_i && !flush_i;
    sel_res = (op_q == MUL) ? lo_q : acc_hi_q;
    // result_q still holds the previous product during DONE, so a flush there shows the old value
    result_o = valid_o ? sel_res : result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MUL;
      mcand_q  <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          op_q     <= mul_op_t'(op_i);
          mcand_q  <= s1 ? -rs1_i : rs1_i;
          lo_q     <= s2 ? -rs2_i : rs2_i;
          acc_hi_q <= '0;
          cnt_q    <= '0;
          neg_q    <= s1 ^ s2;
          c_q      <= 1'b0;
        end
        ST_CALC: begin
          acc_hi_q <= {add_cout, add_sum[XLEN-1:1]};
          lo_q     <= {add_sum[0], lo_q[XLEN-1:1]};
          cnt_q    <= cnt_q + 5'd1;
        end
        ST_FIXLO: begin
          if (neg_q) begin
            lo_q <= add_sum;
            c_q  <= add_cout;
          end else begin
            c_q  <= 1'b0;
          end
        end
        ST_FIXHI: if (neg_q) acc_hi_q <= add_sum;
        ST_DONE:  if (!flush_i) result_q <= sel_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: vector table, 64-bit reference model, result scoreboard.
module tb_mul_iter_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  mul_iter_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 result %h expected no valid", result_o);
      end else begin
        mon_exp = sb.pop_front();
        check32("result", result_o, mon_exp);
      end
    end
  end

  // Issues one op at a negedge and checks busy/valid timing over the fixed latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int bad_busy = 0;
    int nvalid   = 0;
    int vcyc     = 0;
    @(negedge clk);
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int k = 1; k <= int'(MUL_LATENCY); k++) begin
      @(negedge clk);
      if (busy_o !== (k < int'(MUL_LATENCY))) bad_busy++;
      if (valid_o) begin
        nvalid++;
        vcyc = k;
      end
    end
    check32("busy_window_errs", 32'(bad_busy), 32'd0);
    check32("valid_count", 32'(nvalid), 32'd1);
    check32("valid_cycle", 32'(vcyc), 32'(MUL_LATENCY));
  endtask

  initial begin
    logic [31:0] old_res, ra, rb;
    logic [1:0]  rop;
    int nvalid;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; rs1_i = '0; rs2_i = '0;
    repeat (2) @(negedge clk);
    check32("reset_busy", {31'b0, busy_o}, 32'd0);
    check32("reset_valid", {31'b0, valid_o}, 32'd0);
    check32("reset_result", result_o, 32'd0);
    rst = 1'b0;

    vecs.push_back('{2'b00, 32'd7,         32'd6,         32'h0000002A});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF});
    vecs.push_back('{2'b00, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE});
    vecs.push_back('{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE});
    vecs.push_back('{2'b10, 32'h80000000,  32'h80000000,  32'hC0000000});
    vecs.push_back('{2'b01, 32'h80000000,  32'h80000000,  32'h40000000});
    vecs.push_back('{2'b00, 32'h80000000,  32'h80000000,  32'h00000000});
    vecs.push_back('{2'b01, 32'h00000000,  32'hFFFFFFFF,  32'h00000000});
    vecs.push_back('{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000});
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      vecs.push_back('{rop, ra, rb, ref_mul(rop, ra, rb)});
    end
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush mid-CALC at cycle 10, then a fresh op from cycle 12.
    @(negedge clk);
    op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    check32("busy_before_flush", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check32("busy_after_flush", {31'b0, busy_o}, 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 32'h0000000F);

    // Flush during DONE: no pulse, result keeps the previous product.
    old_res = result_o;
    @(negedge clk);
    op_i = 2'b11; rs1_i = 32'hFFFFFFFF; rs2_i = 32'h00000010; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (34) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check32("done_flush_valid", {31'b0, valid_o}, 32'd0);
    check32("done_flush_result", result_o, old_res);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check32("after_done_flush_result", result_o, old_res);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check32("idle_flush_blocks_start", {31'b0, busy_o}, 32'd0);

    // start_i held through a whole op while operands change.
    @(negedge clk);
    op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd4; start_i = 1'b1;
    sb.push_back(32'd12);
    @(posedge clk);
    nvalid = 0;
    for (int k = 1; k <= int'(MUL_LATENCY); k++) begin
      #1 rs1_i = $urandom; rs2_i = $urandom; op_i = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (valid_o) nvalid++;
      @(posedge clk);
    end
    #1 start_i = 1'b0;
    @(negedge clk);
    check32("held_start_valid_count", 32'(nvalid), 32'd1);
    check32("start_in_done_ignored", {31'b0, busy_o}, 32'd0);

    // Async reset at cycle 20 of an op.
    @(negedge clk);
    op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd5; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check32("async_rst_busy", {31'b0, busy_o}, 32'd0);
    check32("async_rst_valid", {31'b0, valid_o}, 32'd0);
    check32("async_rst_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check32("post_rst_busy", {31'b0, busy_o}, 32'd0);
    run_op(2'b10, 32'hFFFFFFFE, 32'd3, ref_mul(2'b10, 32'hFFFFFFFE, 32'd3));

    repeat (2) @(negedge clk);
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
